uart_sys_ctrl: RTL and testbench
================================

// Module: uart_sys_ctrl
// PURPOSE
//  System controller between the UART RX/TX path, the register file and the ALU in the main clock domain.
//  Decodes command frames from already-synchronized RX bytes and sequences register file writes/reads and ALU ops.
//  Returns read data and ALU results to the UART TX through a valid/busy handshake.
// PARAMETERS
//  DATA_W   8    UART byte / register file data width
//  ADDR_W   4    register file address width
//  ALU_W    16   ALU result width; must be 2*DATA_W
//  FUN_W    4    ALU function code width
//  WAIT_TO  255  max cycles spent in a wait state before abort
// PORTS
//  clk             in   1       system clock
//  reset           in   1       asynchronous, active-high reset
//  rx_data_in      in   DATA_W  received byte, valid only with rx_valid_in
//  rx_valid_in     in   1       one-cycle strobe per received byte
//  rf_rd_data_in   in   DATA_W  register file read data
//  rf_rd_valid_in  in   1       register file read data valid strobe
//  alu_out_in      in   ALU_W   ALU result
//  alu_valid_in    in   1       ALU result valid strobe
//  tx_busy_in      in   1       UART TX cannot accept a byte
//  rf_addr_out     out  ADDR_W  register file address
//  rf_wr_data_out  out  DATA_W  register file write data
//  rf_wr_en_out    out  1       one-cycle write strobe
//  rf_rd_en_out    out  1       one-cycle read strobe
//  alu_fun_out     out  FUN_W   ALU function code
//  alu_en_out      out  1       one-cycle ALU start strobe
//  clk_gate_en_out out  1       ALU clock gate enable
//  tx_data_out     out  DATA_W  byte to UART TX
//  tx_valid_out    out  1       tx_data_out valid
//  cmd_err_out     out  1       one-cycle error pulse (bad opcode, overrun, timeout)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, timeout counter 0. All outputs are registered.
//  Opcodes: AA=RF_WR (addr, data); BB=RF_RD (addr); CC=ALU_OP (opA, opB, fun); DD=ALU_NOP (fun).
//  Addresses and the fun code come from the byte LSBs; upper bits are ignored.
//  FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_B0, TX_B1.
//  IDLE: on an rx byte, AA->WR_ADDR, BB->RD_ADDR, CC->OPA, DD->FUN. Any other byte: cmd_err pulse, stay IDLE.
//  WR_ADDR: latch addr, go to WR_DATA. WR_DATA: on the byte, assert rf_wr_en for 1 cycle the next cycle; then IDLE.
//  RD_ADDR: on the byte, rf_rd_en pulses the next cycle; go to RD_WAIT.
//  RD_WAIT: on rf_rd_valid, latch data and go to TX_B0 (single byte).
//  OPA/OPB: each byte is written to RF addr 0 / addr 1 via a 1-cycle rf_wr_en pulse; then OPB / FUN.
//  FUN: on the byte, latch fun and pulse alu_en; go to ALU_WAIT.
//  clk_gate_en_out: high in FUN and ALU_WAIT, and also in the cycle alu_en pulses.
//  ALU_WAIT: on alu_valid, latch the result; go to TX_B0 (LSB), then TX_B1 (MSB).
//  TX handshake: tx_data_out/tx_valid_out stay stable until a cycle where tx_valid_out=1 and tx_busy_in=0.
//    That cycle is the transfer. tx_valid_out drops or advances to the next byte in the following cycle.
//    After the last byte, go to IDLE.
//  Timeout: a counter runs in RD_WAIT, ALU_WAIT and TX states (TX counts only while busy). Reaching WAIT_TO
//    gives a cmd_err pulse, tx_valid 0, IDLE. The counter clears on every state change.
//  Overrun: an rx byte arriving in RD_WAIT/ALU_WAIT/TX_* is dropped with a cmd_err pulse; the sequence continues.
//  Simultaneous events: a completion strobe and a timeout in the same cycle is a completion; no error.
//    An rx byte in the cycle of the final TX transfer counts as an overrun.
//  Stray rf_rd_valid/alu_valid outside the matching wait state are ignored.
//  Reset mid-operation: asynchronous return to IDLE, every output 0, the partial command is discarded.
// STRUCTURE
//  Package uart_sys_pkg: opcode constants (AA/BB/CC/DD), state enum, OPA_ADDR=0, OPB_ADDR=1.
//  Sub-module uart_sys_tx_seq: 2-byte TX sender with handshake and busy timeout, started by (data, nbytes).
// TESTING
//  1. AA,05,3C -> one rf_wr_en pulse with addr=5, data=3C; no tx; state IDLE.
//  2. BB,05; rf_rd_valid with data 3C 2 cycles after rd_en -> exactly one tx transfer of 3C.
//  3. CC,07,03,00; alu_valid with 000A; tx_busy high 5 cycles
//     -> RF writes a0=07, a1=03; alu_en with fun=0; tx 0A then 00, each held stable while busy.
//  4. 55 in IDLE -> one cmd_err pulse, no other strobes; a following AA,01,FF completes normally.
//  5. BB,02 with rf_rd_valid withheld -> cmd_err after WAIT_TO cycles, IDLE, tx_valid never asserted.
//  6. reset pulsed during ALU_WAIT -> all outputs 0 immediately; a subsequent DD,01 then alu_valid gives 2 tx bytes.

Source files
------------

// File: rtl/uart_sys_pkg.sv
// Shared opcodes, FSM state encoding and fixed operand addresses for the UART system controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package uart_sys_pkg;

  // Command opcodes carried in the first byte of every frame
  localparam logic [7:0] OP_RF_WR  = 8'hAA;
  localparam logic [7:0] OP_RF_RD  = 8'hBB;
  localparam logic [7:0] OP_ALU_OP = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  // ALU operands are staged through these two register file slots
  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OPA,
    OPB,
    FUN,
    ALU_WAIT,
    TX_B0,
    TX_B1
  } state_t;

  // True when the byte is one of the four recognised opcodes
  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_RF_WR) || (b == OP_RF_RD) || (b == OP_ALU_OP) || (b == OP_ALU_NOP);
  endfunction

endpackage

// File: rtl/uart_sys_tx_seq.sv
// Sends one or two bytes (LSB first) to the UART TX using a valid/busy handshake.
// Latency: tx_valid_out rises the cycle after start_in; each byte leaves on the first non-busy cycle.
// Backpressure: byte held stable while tx_busy_in; WAIT_TO consecutive busy cycles abort the send.
module uart_sys_tx_seq #(
  parameter int DATA_W  = 8,
  parameter int WAIT_TO = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_in,
  input  logic [2*DATA_W-1:0] start_data_in,
  input  logic [1:0]          nbytes_in,
  input  logic                tx_busy_in,
  output logic [DATA_W-1:0]   tx_data_out,
  output logic                tx_valid_out,
  output logic                xfer_out,
  output logic                last_out,
  output logic                timeout_out
);

  localparam int CNT_W = $clog2(WAIT_TO + 1);

  logic [DATA_W-1:0] hi_q;
  logic              more_q;
  logic [CNT_W-1:0]  cnt_q;

  // Transfer happens in any cycle the byte is offered and the TX is free
  assign xfer_out    = tx_valid_out & ~tx_busy_in;
  assign last_out    = ~more_q;
  assign timeout_out = tx_valid_out & tx_busy_in & (cnt_q == CNT_W'(WAIT_TO - 1));

  // Load on start, advance/drop on transfer, give up after WAIT_TO busy cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data_out  <= '0;
      tx_valid_out <= 1'b0;
      hi_q         <= '0;
      more_q       <= 1'b0;
      cnt_q        <= '0;
    end else if (start_in && !tx_valid_out) begin
      tx_data_out  <= start_data_in[DATA_W-1:0];
      hi_q         <= start_data_in[2*DATA_W-1:DATA_W];
      more_q       <= (nbytes_in == 2'd2);
      tx_valid_out <= 1'b1;
      cnt_q        <= '0;
    end else if (xfer_out) begin
      cnt_q <= '0;
      if (more_q) begin
        tx_data_out <= hi_q;
        more_q      <= 1'b0;
      end else begin
        tx_valid_out <= 1'b0;
      end
    end else if (timeout_out) begin
      tx_valid_out <= 1'b0;
      more_q       <= 1'b0;
      cnt_q        <= '0;
    end else if (tx_valid_out && tx_busy_in) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_sys_ctrl.sv
// Decodes UART command frames into register file writes/reads and ALU ops, returns results over TX.
// Latency: every strobe is registered, one cycle after the byte/strobe that causes it.
// Backpressure: TX bytes wait on tx_busy_in; waits longer than WAIT_TO cycles abort with cmd_err_out.
module uart_sys_ctrl
  import uart_sys_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int ALU_W   = 16,
  parameter int FUN_W   = 4,
  parameter int WAIT_TO = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data_in,
  input  logic              rx_valid_in,
  input  logic [DATA_W-1:0] rf_rd_data_in,
  input  logic              rf_rd_valid_in,
  input  logic [ALU_W-1:0]  alu_out_in,
  input  logic              alu_valid_in,
  input  logic              tx_busy_in,
  output logic [ADDR_W-1:0] rf_addr_out,
  output logic [DATA_W-1:0] rf_wr_data_out,
  output logic              rf_wr_en_out,
  output logic              rf_rd_en_out,
  output logic [FUN_W-1:0]  alu_fun_out,
  output logic              alu_en_out,
  output logic              clk_gate_en_out,
  output logic [DATA_W-1:0] tx_data_out,
  output logic              tx_valid_out,
  output logic              cmd_err_out
);

  localparam int CNT_W = $clog2(WAIT_TO + 1);
  localparam int TX_W  = 2 * DATA_W;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             wait_to;
  logic             rx_is_op;

  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wr_data_d;
  logic [FUN_W-1:0]  fun_d;
  logic              wr_en_d, rd_en_d, alu_en_d, gate_d, err_d;

  logic            tx_start;
  logic [TX_W-1:0] tx_start_data;
  logic [1:0]      tx_nbytes;
  logic            tx_xfer, tx_last, tx_to;

  assign rx_is_op = is_opcode(8'(rx_data_in));
  assign wait_to  = ((state_q == RD_WAIT) || (state_q == ALU_WAIT)) &&
                    (cnt_q == CNT_W'(WAIT_TO - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; a completion strobe wins over a same-cycle timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rx_valid_in) begin
          if      (rx_data_in == DATA_W'(OP_RF_WR))   state_d = WR_ADDR;
          else if (rx_data_in == DATA_W'(OP_RF_RD))   state_d = RD_ADDR;
          else if (rx_data_in == DATA_W'(OP_ALU_OP))  state_d = OPA;
          else if (rx_data_in == DATA_W'(OP_ALU_NOP)) state_d = FUN;
        end
      end
      WR_ADDR:  if (rx_valid_in) state_d = WR_DATA;
      WR_DATA:  if (rx_valid_in) state_d = IDLE;
      RD_ADDR:  if (rx_valid_in) state_d = RD_WAIT;
      RD_WAIT: begin
        if (rf_rd_valid_in) state_d = TX_B0;
        else if (wait_to)   state_d = IDLE;
      end
      OPA:      if (rx_valid_in) state_d = OPB;
      OPB:      if (rx_valid_in) state_d = FUN;
      FUN:      if (rx_valid_in) state_d = ALU_WAIT;
      ALU_WAIT: begin
        if (alu_valid_in) state_d = TX_B0;
        else if (wait_to) state_d = IDLE;
      end
      TX_B0: begin
        if (tx_xfer)    state_d = tx_last ? IDLE : TX_B1;
        else if (tx_to) state_d = IDLE;
      end
      TX_B1:    if (tx_xfer || tx_to) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output next-values; rx bytes during any wait are overruns
  always_comb begin
    addr_d        = rf_addr_out;
    wr_data_d     = rf_wr_data_out;
    fun_d         = alu_fun_out;
    wr_en_d       = 1'b0;
    rd_en_d       = 1'b0;
    alu_en_d      = 1'b0;
    err_d         = 1'b0;
    tx_start      = 1'b0;
    tx_start_data = '0;
    tx_nbytes     = 2'd0;
    unique case (state_q)
      IDLE:    if (rx_valid_in && !rx_is_op) err_d = 1'b1;
      WR_ADDR: if (rx_valid_in) addr_d = rx_data_in[ADDR_W-1:0];
      WR_DATA: begin
        if (rx_valid_in) begin
          wr_data_d = rx_data_in;
          wr_en_d   = 1'b1;
        end
      end
      RD_ADDR: begin
        if (rx_valid_in) begin
          addr_d  = rx_data_in[ADDR_W-1:0];
          rd_en_d = 1'b1;
        end
      end
      RD_WAIT: begin
        if (rf_rd_valid_in) begin
          tx_start      = 1'b1;
          tx_start_data = TX_W'(rf_rd_data_in);
          tx_nbytes     = 2'd1;
        end else if (wait_to) begin
          err_d = 1'b1;
        end
        if (rx_valid_in) err_d = 1'b1;
      end
      OPA: begin
        if (rx_valid_in) begin
          addr_d    = ADDR_W'(OPA_ADDR);
          wr_data_d = rx_data_in;
          wr_en_d   = 1'b1;
        end
      end
      OPB: begin
        if (rx_valid_in) begin
          addr_d    = ADDR_W'(OPB_ADDR);
          wr_data_d = rx_data_in;
          wr_en_d   = 1'b1;
        end
      end
      FUN: begin
        if (rx_valid_in) begin
          fun_d    = rx_data_in[FUN_W-1:0];
          alu_en_d = 1'b1;
        end
      end
      ALU_WAIT: begin
        if (alu_valid_in) begin
          tx_start      = 1'b1;
          tx_start_data = TX_W'(alu_out_in);
          tx_nbytes     = 2'd2;
        end else if (wait_to) begin
          err_d = 1'b1;
        end
        if (rx_valid_in) err_d = 1'b1;
      end
      TX_B0, TX_B1: if (tx_to || rx_valid_in) err_d = 1'b1;
      default: ;
    endcase
  end

  // ALU clock stays on from the opcode byte until the result is taken
  assign gate_d = (state_d == FUN) || (state_d == ALU_WAIT);

  // Wait-state cycle counter, cleared on every state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                            cnt_q <= '0;
    else if (state_d != state_q)                          cnt_q <= '0;
    else if ((state_q == RD_WAIT) || (state_q == ALU_WAIT)) cnt_q <= cnt_q + CNT_W'(1);
  end

  // Registered outputs toward the register file and ALU
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_addr_out     <= '0;
      rf_wr_data_out  <= '0;
      rf_wr_en_out    <= 1'b0;
      rf_rd_en_out    <= 1'b0;
      alu_fun_out     <= '0;
      alu_en_out      <= 1'b0;
      clk_gate_en_out <= 1'b0;
      cmd_err_out     <= 1'b0;
    end else begin
      rf_addr_out     <= addr_d;
      rf_wr_data_out  <= wr_data_d;
      rf_wr_en_out    <= wr_en_d;
      rf_rd_en_out    <= rd_en_d;
      alu_fun_out     <= fun_d;
      alu_en_out      <= alu_en_d;
      clk_gate_en_out <= gate_d;
      cmd_err_out     <= err_d;
    end
  end

  uart_sys_tx_seq #(
    .DATA_W  (DATA_W),
    .WAIT_TO (WAIT_TO)
  ) u_tx_seq (
    .clk           (clk),
    .reset         (reset),
    .start_in      (tx_start),
    .start_data_in (tx_start_data),
    .nbytes_in     (tx_nbytes),
    .tx_busy_in    (tx_busy_in),
    .tx_data_out   (tx_data_out),
    .tx_valid_out  (tx_valid_out),
    .xfer_out      (tx_xfer),
    .last_out      (tx_last),
    .timeout_out   (tx_to)
  );

endmodule

// File: tb/tb_uart_sys_ctrl.sv
// Scoreboard bench for uart_sys_ctrl: directed frames push expected events, a negedge monitor pops them.
// Latency: n/a.
// Backpressure: tx_busy_in driven by the stimulus to exercise the hold behaviour.
module tb_uart_sys_ctrl;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int ALU_W   = 16;
  localparam int FUN_W   = 4;
  localparam int WAIT_TO = 255;
  localparam int BOUND   = 600;

  localparam logic [2:0] EV_WR  = 3'd1;
  localparam logic [2:0] EV_RD  = 3'd2;
  localparam logic [2:0] EV_ALU = 3'd3;
  localparam logic [2:0] EV_TX  = 3'd4;
  localparam logic [2:0] EV_ERR = 3'd5;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] rx_data_in;
  logic              rx_valid_in;
  logic [DATA_W-1:0] rf_rd_data_in;
  logic              rf_rd_valid_in;
  logic [ALU_W-1:0]  alu_out_in;
  logic              alu_valid_in;
  logic              tx_busy_in;
  logic [ADDR_W-1:0] rf_addr_out;
  logic [DATA_W-1:0] rf_wr_data_out;
  logic              rf_wr_en_out;
  logic              rf_rd_en_out;
  logic [FUN_W-1:0]  alu_fun_out;
  logic              alu_en_out;
  logic              clk_gate_en_out;
  logic [DATA_W-1:0] tx_data_out;
  logic              tx_valid_out;
  logic              cmd_err_out;

  int   tests;
  int   fails;
  int   cyc;
  int   rd_en_cyc;
  int   err_cyc;
  ev_t  exp_q[$];
  logic hold_prev;
  logic [7:0] hold_data;

  uart_sys_ctrl #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .ALU_W (ALU_W), .FUN_W (FUN_W), .WAIT_TO (WAIT_TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rx_data_in      (rx_data_in),
    .rx_valid_in     (rx_valid_in),
    .rf_rd_data_in   (rf_rd_data_in),
    .rf_rd_valid_in  (rf_rd_valid_in),
    .alu_out_in      (alu_out_in),
    .alu_valid_in    (alu_valid_in),
    .tx_busy_in      (tx_busy_in),
    .rf_addr_out     (rf_addr_out),
    .rf_wr_data_out  (rf_wr_data_out),
    .rf_wr_en_out    (rf_wr_en_out),
    .rf_rd_en_out    (rf_rd_en_out),
    .alu_fun_out     (alu_fun_out),
    .alu_en_out      (alu_en_out),
    .clk_gate_en_out (clk_gate_en_out),
    .tx_data_out     (tx_data_out),
    .tx_valid_out    (tx_valid_out),
    .cmd_err_out     (cmd_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ev_t mk(input logic [2:0] k, input logic [7:0] aa, input logic [7:0] dd);
    return {k, aa, dd};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic observe(input ev_t got);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind=%0d a=%h d=%h required none", got.kind, got.a, got.d);
    end else begin
      e = exp_q.pop_front();
      if (e !== got) begin
        fails++;
        $display("FAIL event: got kind=%0d a=%h d=%h required kind=%0d a=%h d=%h",
                 got.kind, got.a, got.d, e.kind, e.a, e.d);
      end
    end
  endtask

  // Monitor: samples on the falling edge, turns strobes into events
  initial begin
    cyc = 0; rd_en_cyc = 0; err_cyc = 0; hold_prev = 1'b0; hold_data = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          chk("tx_hold_valid", 32'(tx_valid_out), 32'd1);
          chk("tx_hold_data", 32'(tx_data_out), 32'(hold_data));
        end
        if (rf_wr_en_out) observe(mk(EV_WR, {4'h0, rf_addr_out}, rf_wr_data_out));
        if (rf_rd_en_out) begin
          rd_en_cyc = cyc;
          observe(mk(EV_RD, {4'h0, rf_addr_out}, 8'h00));
        end
        if (alu_en_out) observe(mk(EV_ALU, {4'h0, alu_fun_out}, 8'h00));
        if (tx_valid_out && !tx_busy_in) observe(mk(EV_TX, 8'h00, tx_data_out));
        if (cmd_err_out) begin
          err_cyc = cyc;
          observe(mk(EV_ERR, 8'h00, 8'h00));
        end
        hold_prev = tx_valid_out && tx_busy_in;
        hold_data = tx_data_out;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data_in  = b;
    rx_valid_in = 1'b1;
    tick();
    rx_valid_in = 1'b0;
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return rf_rd_en_out;
      1:       return alu_en_out;
      default: return cmd_err_out;
    endcase
  endfunction

  task automatic wait_out(input int w, input string name);
    int n = 0;
    while (!sel(w) && n < BOUND) begin
      tick();
      n++;
    end
    chk(name, 32'(sel(w)), 32'd1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || tx_valid_out) && n < BOUND) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_zero(input string name);
    chk(name, 32'({rf_addr_out, rf_wr_data_out, rf_wr_en_out, rf_rd_en_out, alu_fun_out,
                   alu_en_out, clk_gate_en_out, tx_data_out, tx_valid_out, cmd_err_out}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1;
    rx_data_in = '0; rx_valid_in = 1'b0;
    rf_rd_data_in = '0; rf_rd_valid_in = 1'b0;
    alu_out_in = '0; alu_valid_in = 1'b0; tx_busy_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_outputs");
    reset = 1'b0;
    tick();

    // 1: register write
    exp_q.push_back(mk(EV_WR, 8'h05, 8'h3C));
    send(8'hAA); send(8'h05); send(8'h3C);
    drain("t1_rf_wr");

    // 2: register read, single TX byte
    exp_q.push_back(mk(EV_RD, 8'h05, 8'h00));
    exp_q.push_back(mk(EV_TX, 8'h00, 8'h3C));
    send(8'hBB); send(8'h05);
    wait_out(0, "t2_rd_en_seen");
    tick(); tick();
    rf_rd_data_in = 8'h3C; rf_rd_valid_in = 1'b1;
    tick();
    rf_rd_valid_in = 1'b0;
    drain("t2_rf_rd");

    // 3: ALU op with TX backpressure
    exp_q.push_back(mk(EV_WR, 8'h00, 8'h07));
    exp_q.push_back(mk(EV_WR, 8'h01, 8'h03));
    exp_q.push_back(mk(EV_ALU, 8'h00, 8'h00));
    exp_q.push_back(mk(EV_TX, 8'h00, 8'h0A));
    exp_q.push_back(mk(EV_TX, 8'h00, 8'h00));
    send(8'hCC); send(8'h07); send(8'h03); send(8'h00);
    wait_out(1, "t3_alu_en_seen");
    chk("t3_clk_gate_on", 32'(clk_gate_en_out), 32'd1);
    tx_busy_in = 1'b1;
    tick();
    alu_out_in = 16'h000A; alu_valid_in = 1'b1;
    tick();
    alu_valid_in = 1'b0;
    chk("t3_tx_valid_busy", 32'(tx_valid_out), 32'd1);
    repeat (5) tick();
    tx_busy_in = 1'b0;
    drain("t3_alu_op");
    chk("t3_clk_gate_off", 32'(clk_gate_en_out), 32'd0);

    // 4: bad opcode then a normal write
    exp_q.push_back(mk(EV_ERR, 8'h00, 8'h00));
    exp_q.push_back(mk(EV_WR, 8'h01, 8'hFF));
    send(8'h55); send(8'hAA); send(8'h01); send(8'hFF);
    drain("t4_bad_opcode");

    // 5: read data never returns
    exp_q.push_back(mk(EV_RD, 8'h02, 8'h00));
    exp_q.push_back(mk(EV_ERR, 8'h00, 8'h00));
    send(8'hBB); send(8'h02);
    wait_out(0, "t5_rd_en_seen");
    wait_out(2, "t5_timeout_seen");
    drain("t5_timeout");
    chk("t5_timeout_cycles", 32'(err_cyc - rd_en_cyc), 32'(WAIT_TO));

    // 6: reset during ALU_WAIT, then ALU_NOP
    exp_q.push_back(mk(EV_WR, 8'h00, 8'h01));
    exp_q.push_back(mk(EV_WR, 8'h01, 8'h02));
    exp_q.push_back(mk(EV_ALU, 8'h03, 8'h00));
    send(8'hCC); send(8'h01); send(8'h02); send(8'h03);
    wait_out(1, "t6_alu_en_seen");
    tick(); tick();
    reset = 1'b1;
    #1;
    chk_zero("t6_reset_mid");
    chk("t6_queue_before_reset", 32'(exp_q.size()), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    exp_q.push_back(mk(EV_ALU, 8'h01, 8'h00));
    exp_q.push_back(mk(EV_TX, 8'h00, 8'h34));
    exp_q.push_back(mk(EV_TX, 8'h00, 8'h12));
    send(8'hDD); send(8'h01);
    wait_out(1, "t6_nop_alu_en_seen");
    tick();
    alu_out_in = 16'h1234; alu_valid_in = 1'b1;
    tick();
    alu_valid_in = 1'b0;
    drain("t6_alu_nop");

    // 7: overrun during RD_WAIT, read still completes
    exp_q.push_back(mk(EV_RD, 8'h03, 8'h00));
    exp_q.push_back(mk(EV_ERR, 8'h00, 8'h00));
    exp_q.push_back(mk(EV_TX, 8'h00, 8'h5A));
    send(8'hBB); send(8'h03); send(8'h77);
    tick();
    rf_rd_data_in = 8'h5A; rf_rd_valid_in = 1'b1;
    tick();
    rf_rd_valid_in = 1'b0;
    drain("t7_overrun");

    // 8: rx byte in the final TX transfer cycle is an overrun
    exp_q.push_back(mk(EV_RD, 8'h04, 8'h00));
    exp_q.push_back(mk(EV_TX, 8'h00, 8'h66));
    exp_q.push_back(mk(EV_ERR, 8'h00, 8'h00));
    send(8'hBB); send(8'h04);
    tick();
    rf_rd_data_in = 8'h66; rf_rd_valid_in = 1'b1;
    tick();
    rf_rd_valid_in = 1'b0;
    send(8'h99);
    drain("t8_overrun_last_xfer");

    // 9: stray completion strobes in IDLE are ignored
    rf_rd_valid_in = 1'b1; alu_valid_in = 1'b1;
    tick(); tick();
    rf_rd_valid_in = 1'b0; alu_valid_in = 1'b0;
    exp_q.push_back(mk(EV_WR, 8'h0F, 8'h81));
    send(8'hAA); send(8'h0F); send(8'h81);
    drain("t9_stray_strobes");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
